// File: rtl/async_fifo_rd_ctrl_if.sv
// Output word stream of the async FIFO read controller: data with valid/ready handshake.
interface async_fifo_rd_ctrl_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] m_data;
  logic             m_valid;
  logic             m_ready;

  modport master (output m_data, output m_valid, input m_ready);
  modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/async_fifo_rd_ctrl.sv
// Read-side controller of the async FIFO, entirely in the rd_clk domain.
// Define RD_LEVEL_EN to build the registered rd_level fill counter; otherwise rd_level is 0.
module async_fifo_rd_ctrl #(
  parameter int WIDTH       = 8,
  parameter int PTR_LEN     = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 rd_clk,
  input  logic                 rst,
  input  logic [PTR_LEN:0]     wr_ptr_gray_i,
  output logic [PTR_LEN:0]     rd_ptr_gray_o,
  output logic [PTR_LEN:0]     rd_ptr_o,
  output logic                 rd_en_o,
  input  logic [WIDTH-1:0]     mem_data_i,
  async_fifo_rd_ctrl_if.master strm,
  output logic                 empty,
  output logic [PTR_LEN:0]     rd_level
);

  localparam logic [PTR_LEN:0] PTR_ONE = {{PTR_LEN{1'b0}}, 1'b1};

  function automatic logic [PTR_LEN:0] bin2gray(input logic [PTR_LEN:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [PTR_LEN:0] sync_r [SYNC_STAGES];
  logic [PTR_LEN:0] wr_gray_s;
  logic [PTR_LEN:0] rd_ptr_r;
  logic [PTR_LEN:0] rd_gray_r;
  logic [PTR_LEN:0] rd_ptr_inc_s;
  logic [WIDTH-1:0] m_data_r;
  logic             m_valid_r;
  logic             empty_s;
  logic             load_s;

  // Write-pointer synchronizer chain into rd_clk
  always_ff @(posedge rd_clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_r[i] <= '0;
    end else begin
      sync_r[0] <= wr_ptr_gray_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_r[i] <= sync_r[i-1];
    end
  end

  assign wr_gray_s = sync_r[SYNC_STAGES-1];

  // Empty compares Gray pointers directly, so no decoder is needed for it
  always_comb begin
    empty_s      = (rd_gray_r == wr_gray_s);
    load_s       = ~empty_s && (~m_valid_r || strm.m_ready);
    rd_ptr_inc_s = rd_ptr_r + PTR_ONE;
  end

  // Pointer advance and output word register; a stalled word holds the pointer
  always_ff @(posedge rd_clk or posedge rst) begin
    if (rst) begin
      rd_ptr_r  <= '0;
      rd_gray_r <= '0;
      m_data_r  <= '0;
      m_valid_r <= 1'b0;
    end else if (load_s) begin
      m_data_r  <= mem_data_i;
      m_valid_r <= 1'b1;
      rd_ptr_r  <= rd_ptr_inc_s;
      rd_gray_r <= bin2gray(rd_ptr_inc_s);
    end else if (m_valid_r && strm.m_ready) begin
      m_valid_r <= 1'b0;
    end
  end

  assign rd_ptr_o      = rd_ptr_r;
  assign rd_ptr_gray_o = rd_gray_r;
  assign rd_en_o       = ~empty_s;
  assign empty         = empty_s;
  assign strm.m_data   = m_data_r;
  assign strm.m_valid  = m_valid_r;

`ifdef RD_LEVEL_EN
  function automatic logic [PTR_LEN:0] gray2bin(input logic [PTR_LEN:0] g);
    logic [PTR_LEN:0] b;
    b[PTR_LEN] = g[PTR_LEN];
    for (int i = PTR_LEN - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  logic [PTR_LEN:0] wr_bin_s;
  logic [PTR_LEN:0] rd_ptr_next_s;
  logic [PTR_LEN:0] level_r;

  // Level excludes the word already parked in m_data
  always_comb begin
    wr_bin_s = gray2bin(wr_gray_s);
    if (load_s) begin
      rd_ptr_next_s = rd_ptr_inc_s;
    end else begin
      rd_ptr_next_s = rd_ptr_r;
    end
  end

  // Fill-level register, modulo 2**(PTR_LEN+1)
  always_ff @(posedge rd_clk or posedge rst) begin
    if (rst) begin
      level_r <= '0;
    end else begin
      level_r <= wr_bin_s - rd_ptr_next_s;
    end
  end

  assign rd_level = level_r;
`else
  assign rd_level = '0;
`endif

endmodule

// File: tb/tb_async_fifo_rd_ctrl.sv
// Directed self-checking bench for async_fifo_rd_ctrl with a small write-side and BRAM model.
module tb_async_fifo_rd_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] wr_gray;
  logic [4:0] wr_bin;
  logic [4:0] rd_gray;
  logic [4:0] rd_ptr;
  logic       rd_en;
  logic [7:0] mem_data;
  logic       empty;
  logic [4:0] rd_level;
  logic [7:0] mem [16];

  logic [7:0] got_q [$];
  int         beat_q [$];
  int         cyc = 0;
  int         errors = 0;
  int         checks = 0;
  logic [4:0] exp_rd;
  int         pushed;
  logic [4:0] exp_level;

  async_fifo_rd_ctrl_if #(.WIDTH(8)) strm ();

  async_fifo_rd_ctrl #(.WIDTH(8), .PTR_LEN(4), .SYNC_STAGES(2)) dut (
    .rd_clk        (clk),
    .rst           (rst),
    .wr_ptr_gray_i (wr_gray),
    .rd_ptr_gray_o (rd_gray),
    .rd_ptr_o      (rd_ptr),
    .rd_en_o       (rd_en),
    .mem_data_i    (mem_data),
    .strm          (strm),
    .empty         (empty),
    .rd_level      (rd_level)
  );

  always #5 clk = ~clk;

  assign mem_data = mem[rd_ptr[3:0]];

  function automatic logic [4:0] gray(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Record the beat the next edge will accept, then advance to 1 time unit after it
  task automatic cycle();
    if (strm.m_valid && strm.m_ready) begin
      got_q.push_back(strm.m_data);
      beat_q.push_back(cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic push(input logic [7:0] d);
    mem[wr_bin[3:0]] = d;
    wr_bin  = wr_bin + 5'd1;
    wr_gray = gray(wr_bin);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    rst = 1'b1;
    wr_bin = 5'd0;
    wr_gray = 5'd0;
    strm.m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // 1: idle after reset
    for (int i = 0; i < 10; i++) begin
      cycle();
      check_value("rst m_valid", strm.m_valid, 1'b0);
      check_value("rst empty", empty, 1'b1);
      check_value("rst rd_ptr", rd_ptr, 5'd0);
      check_value("rst rd_gray", rd_gray, 5'd0);
      check_value("rst rd_level", rd_level, 5'd0);
    end

    // 2: single word latency
    strm.m_ready = 1'b1;
    push(8'hA5);
    cycle();
    check_value("t2 empty e1", empty, 1'b1);
    cycle();
    check_value("t2 empty e2", empty, 1'b0);
    check_value("t2 rd_en e2", rd_en, 1'b1);
    check_value("t2 m_valid e2", strm.m_valid, 1'b0);
    cycle();
    check_value("t2 m_valid e3", strm.m_valid, 1'b1);
    check_value("t2 m_data e3", strm.m_data, 8'hA5);
    check_value("t2 rd_ptr e3", rd_ptr, 5'd1);
    check_value("t2 rd_gray e3", rd_gray, 5'd1);
    check_value("t2 empty e3", empty, 1'b1);
    cycle();
    check_value("t2 m_valid e4", strm.m_valid, 1'b0);
    check_value("t2 m_data hold", strm.m_data, 8'hA5);
    check_value("t2 beats", got_q.size(), 32'd1);
    exp_rd = 5'd1;

    // 3: two 16-word bursts, the second wrapping the pointer
    for (int pass = 0; pass < 2; pass++) begin
      got_q.delete();
      beat_q.delete();
      pushed = 0;
      for (int t = 0; t < 80 && got_q.size() < 16; t++) begin
        if (pushed < 16) begin
          push(8'(pushed + pass * 16));
          pushed++;
        end
        cycle();
      end
      repeat (3) cycle();
      exp_rd = exp_rd + 5'd16;
      check_value("t3 beats", got_q.size(), 32'd16);
      for (int i = 0; i < 16 && i < got_q.size(); i++)
        check_value("t3 data", got_q[i], 32'(i + pass * 16));
      if (beat_q.size() == 16)
        check_value("t3 back-to-back", beat_q[15] - beat_q[0], 32'd15);
      check_value("t3 rd_ptr", rd_ptr, exp_rd);
      check_value("t3 rd_gray", rd_gray, gray(exp_rd));
      check_value("t3 empty", empty, 1'b1);
      check_value("t3 m_valid", strm.m_valid, 1'b0);
    end

    // 4: backpressure holds word and pointer
    got_q.delete();
    strm.m_ready = 1'b0;
    push(8'hB0);
    cycle();
    push(8'hB1);
    cycle();
    push(8'hB2);
    cycle();
    for (int i = 0; i < 5; i++) begin
      cycle();
      check_value("t4 m_valid", strm.m_valid, 1'b1);
      check_value("t4 m_data", strm.m_data, 8'hB0);
      check_value("t4 rd_ptr", rd_ptr, exp_rd + 5'd1);
    end
    strm.m_ready = 1'b1;
    repeat (10) cycle();
    exp_rd = exp_rd + 5'd3;
    check_value("t4 beats", got_q.size(), 32'd3);
    for (int i = 0; i < 3 && i < got_q.size(); i++)
      check_value("t4 data", got_q[i], 32'(8'hB0 + i));
    check_value("t4 rd_ptr end", rd_ptr, exp_rd);

    // 5: reset in the middle of a stream
    got_q.delete();
    pushed = 0;
    for (int t = 0; t < 60 && got_q.size() < 7; t++) begin
      if (pushed < 16) begin
        push(8'(8'h60 + pushed));
        pushed++;
      end
      cycle();
    end
    check_value("t5 pre beats", got_q.size(), 32'd7);
    rst = 1'b1;
    wr_bin = 5'd0;
    wr_gray = 5'd0;
    #1;
    check_value("t5 m_valid", strm.m_valid, 1'b0);
    check_value("t5 rd_ptr", rd_ptr, 5'd0);
    check_value("t5 rd_gray", rd_gray, 5'd0);
    check_value("t5 empty", empty, 1'b1);
    #1;
    repeat (3) cycle();
    rst = 1'b0;
    got_q.delete();
    push(8'h3C);
    for (int t = 0; t < 10 && got_q.size() < 1; t++) cycle();
    check_value("t5 first word", got_q.size() > 0 ? got_q[0] : 8'h00, 8'h3C);
    repeat (3) cycle();
    check_value("t5 beats", got_q.size(), 32'd1);

    // 6: fill level with a stalled consumer
    got_q.delete();
    strm.m_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      push(8'(8'h50 + i));
      cycle();
    end
    repeat (4) cycle();
`ifdef RD_LEVEL_EN
    exp_level = 5'd9;
`else
    exp_level = 5'd0;
`endif
    check_value("t6 m_valid", strm.m_valid, 1'b1);
    check_value("t6 m_data", strm.m_data, 8'h50);
    check_value("t6 level", rd_level, exp_level);
    strm.m_ready = 1'b1;
    repeat (20) cycle();
    check_value("t6 beats", got_q.size(), 32'd10);
    check_value("t6 last", got_q.size() == 10 ? got_q[9] : 8'h00, 8'h59);
    check_value("t6 level end", rd_level, 5'd0);
    check_value("t6 empty", empty, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
